spi_slave_base: RTL and testbench
=================================

# spi_slave_base

SPI responder (mode 0, CPOL=0/CPHA=0, MSB first, 8-bit frames) for the MSI-URC mobility board. It is the far-end counterpart of the mobility SPI host and lets an FPGA-side peripheral (motor controller, encoder concentrator) answer a master. It synchronizes the external `ss_n`/`sck`/`mosi` into `clk`, shifts bytes in and out, and exposes a one-deep TX holding buffer plus a one-cycle RX strobe to local logic.

## Interface
- `SYNC_STAGES`, default 2: flip-flop stages on each of `ss_n`, `sck`, `mosi`; legal values ≥ 2.
- `IDLE_BYTE`, default 8'h00: byte shifted out when no TX byte is buffered at frame/byte start.

- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high; clock `clk`.
- `ss_n`  in  1  slave select from master, active-low, asynchronous.
- `sck`  in  1  SPI clock from master, asynchronous.
- `mosi`  in  1  master-out data, asynchronous.
- `miso`  out  1  slave-out data; valid while `miso_oe`=1.
- `miso_oe`  out  1  output enable for the MISO pad tristate.
- `tx_data`  in  8  byte to send next.
- `tx_load`  in  1  write `tx_data` into the TX holding buffer.
- `tx_ready`  out  1  TX holding buffer empty.
- `rx_data`  out  8  last complete received byte; holds until the next byte completes.
- `rx_valid`  out  1  one-cycle strobe: `rx_data` updated.
- `busy`  out  1  `ss_n` (synchronized) low.
- `overrun`  out  1  sticky: `tx_load` while `tx_ready`=0.
- `underrun`  out  1  sticky: byte started with an empty buffer.
- `status_clr`  in  1  clears `overrun`/`underrun`.

## Operation
- Synchronizers yield `ss_s`, `sck_s`, `mosi_s`; one extra register on `ss_s`/`sck_s` gives edge detects `ss_fall`, `ss_rise`, `sck_rise`, `sck_fall`.
- States: IDLE (`ss_s`=1) and ACTIVE (`ss_s`=0). IDLE→ACTIVE on `ss_fall`; ACTIVE→IDLE on `ss_rise`. In IDLE, `sck`/`mosi` edges are ignored.
- On `ss_fall`: `bit_ctr`←0; TX shifter←holding buffer if full (buffer marked empty), else `IDLE_BYTE` and `underrun` set.
- `miso` = shifter[7]; `miso_oe` = ACTIVE.
- `sck_rise` in ACTIVE: `rx_shift`←{`rx_shift`[6:0], `mosi_s`}; `bit_ctr`++. When `bit_ctr` was 7: `rx_data`←{`rx_shift`[6:0], `mosi_s`}, `rx_valid`=1 next cycle, `bit_ctr` wraps to 0, and the `byte_done` flag is set.
- `sck_fall` in ACTIVE: if `byte_done`, the shifter reloads from the buffer (or `IDLE_BYTE` + `underrun`) and `byte_done` clears; otherwise the shifter shifts left by 1.
- `tx_load` with `tx_ready`=1 fills the buffer. With `tx_ready`=0 it is ignored and `overrun` is set.
- Simultaneous `tx_load` and a buffer consume in the same cycle: the consume takes the old content and the new byte is stored. `tx_ready` stays 0 and no overrun is flagged.
- `ss_rise` mid-byte: the partial RX byte is discarded, with no `rx_valid`. `bit_ctr` and `byte_done` are cleared. The consumed TX byte is not restored.
- `status_clr` has priority over a simultaneous set.

## Timing
- Reset values: `miso`=0, `miso_oe`=0, `tx_ready`=1, `rx_data`=8'h00, `rx_valid`=0, `busy`=0, `overrun`=0, `underrun`=0, state IDLE.
- Latency: an external edge is acted on SYNC_STAGES+1 clk edges after the first clk edge that samples it. `rx_valid` rises one clk after that action.
- `miso` changes one clk after the internal `sck_fall`/`ss_fall` action.
- Requirements on the master:
  - `sck` high and low phases ≥ SYNC_STAGES+2 clk each.
  - `ss_n` fall to first `sck` rise ≥ SYNC_STAGES+3 clk.
- `tx_load` must precede the consuming edge action by ≥ 1 clk to be sent in that byte.

## Configuration
- `SPI_SLAVE_STATUS_EN` defined: `overrun`/`underrun` sticky flags and `status_clr` are implemented as above.
- Not defined: `overrun`/`underrun` are tied to 0, `status_clr` is ignored, and no flag registers exist. Data-path behaviour is identical.

## Test plan
- Reset, then idle: all outputs at their reset values; `miso_oe`=0 while `ss_n`=1 and `sck` is toggling.
- Load 8'hA5, send frame with mosi byte 8'h3C: the master samples 8'hA5 on `miso`; `rx_data`=8'h3C, and `rx_valid` pulses once for exactly 1 clk.
- Two-byte frame, loading 8'h12 then 8'h34 as `tx_ready` rises, mosi 8'hF0, 8'h0F: `miso` carries 8'h12, 8'h34; two `rx_valid` pulses with 8'hF0, 8'h0F; `underrun`=0.
- Empty buffer at `ss_fall`: `miso` carries 8'h00; `underrun`=1 (macro defined) or 0 (undefined); `status_clr` returns it to 0.
- `ss_n` deasserted after 5 bits: no `rx_valid`, `rx_data` unchanged, `miso_oe`=0. The next full frame receives correctly.
- `tx_load` twice with no frame: `overrun`=1, and the buffer retains the first byte, which is shifted out in the next frame.

Source files
------------

// File: rtl/spi_slave_base.sv
// spi_slave_base: SPI mode-0 responder (CPOL=0, CPHA=0, MSB first, 8-bit frames).
// Synchronizes ss_n/sck/mosi into clk, shifts bytes in and out, and offers a
// one-deep TX holding buffer plus a one-cycle RX strobe to local logic.
//
// Parameters:
//   SYNC_STAGES  flop stages on each of ss_n, sck, mosi (>= 2)
//   IDLE_BYTE    byte sent when the TX buffer is empty at frame/byte start
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   ss_n, sck, mosi     asynchronous SPI inputs from the master
//   miso, miso_oe       slave data out and its pad output enable
//   tx_data, tx_load    write a byte into the TX holding buffer
//   tx_ready            TX holding buffer empty
//   rx_data, rx_valid   last received byte and its one-cycle update strobe
//   busy                synchronized ss_n is low
//   overrun, underrun   sticky status flags, cleared by status_clr
// Build option:
//   SPI_SLAVE_STATUS_EN  when defined, overrun/underrun flags are implemented;
//                        otherwise they read 0 and status_clr is ignored.
module spi_slave_base #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  IDLE_BYTE   = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ss_n,
  input  logic       sck,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       overrun,
  output logic       underrun,
  input  logic       status_clr
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CTR_W  = 3;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] ss_sync_q, sck_sync_q, mosi_sync_q;
  logic ss_s, sck_s, mosi_s;
  logic ss_d_q, sck_d_q;
  logic ss_fall, ss_rise, sck_rise, sck_fall;

  logic [CTR_W-1:0]  bit_ctr_q, bit_ctr_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0] rx_data_d;
  logic              rx_valid_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic              tx_ready_d;
  logic              byte_done_q, byte_done_d;
  logic              consume;
  logic              ovr_set, udr_set;

  // Input synchronizers plus one delay stage for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      ss_sync_q   <= '1;
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      ss_d_q      <= 1'b1;
      sck_d_q     <= 1'b0;
    end else begin
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss_n};
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      ss_d_q      <= ss_s;
      sck_d_q     <= sck_s;
    end
  end

  assign ss_s     = ss_sync_q[SYNC_STAGES-1];
  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign ss_fall  = ss_d_q & ~ss_s;
  assign ss_rise  = ~ss_d_q & ss_s;
  assign sck_rise = ~sck_d_q & sck_s;
  assign sck_fall = sck_d_q & ~sck_s;

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_ctr_q   <= '0;
      rx_shift_q  <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_shift_q  <= '0;
      buf_q       <= '0;
      tx_ready    <= 1'b1;
      byte_done_q <= 1'b0;
      miso        <= 1'b0;
      miso_oe     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_ctr_q   <= bit_ctr_d;
      rx_shift_q  <= rx_shift_d;
      rx_data     <= rx_data_d;
      rx_valid    <= rx_valid_d;
      tx_shift_q  <= tx_shift_d;
      buf_q       <= buf_d;
      tx_ready    <= tx_ready_d;
      byte_done_q <= byte_done_d;
      // miso follows the shifter one clk after it changes
      miso        <= tx_shift_q[DATA_W-1];
      miso_oe     <= (state_d == ACTIVE);
      busy        <= ~ss_s;
    end
  end

  // Next-state, shift and TX-buffer logic
  always_comb begin
    state_d     = state_q;
    bit_ctr_d   = bit_ctr_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data;
    rx_valid_d  = 1'b0;
    tx_shift_d  = tx_shift_q;
    buf_d       = buf_q;
    tx_ready_d  = tx_ready;
    byte_done_d = byte_done_q;
    consume     = 1'b0;
    ovr_set     = 1'b0;
    udr_set     = 1'b0;

    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d     = ACTIVE;
          bit_ctr_d   = '0;
          byte_done_d = 1'b0;
          consume     = 1'b1;
        end
      end
      ACTIVE: begin
        if (ss_rise) begin
          // Partial byte is dropped; a consumed TX byte is not restored
          state_d     = IDLE;
          bit_ctr_d   = '0;
          byte_done_d = 1'b0;
        end else if (sck_rise) begin
          rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_s};
          bit_ctr_d  = bit_ctr_q + CTR_W'(1);
          if (bit_ctr_q == CTR_W'(7)) begin
            rx_data_d   = {rx_shift_q[DATA_W-2:0], mosi_s};
            rx_valid_d  = 1'b1;
            byte_done_d = 1'b1;
          end
        end else if (sck_fall) begin
          if (byte_done_q) begin
            consume     = 1'b1;
            byte_done_d = 1'b0;
          end else begin
            tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Shifter reload from the holding buffer, or the idle byte when empty
    if (consume) begin
      if (!tx_ready) begin
        tx_shift_d = buf_q;
        tx_ready_d = 1'b1;
      end else begin
        tx_shift_d = IDLE_BYTE;
        udr_set    = 1'b1;
      end
    end

    // A load coinciding with a consume is accepted: the consume took the old byte
    if (tx_load) begin
      if (tx_ready || consume) begin
        buf_d      = tx_data;
        tx_ready_d = 1'b0;
      end else begin
        ovr_set = 1'b1;
      end
    end
  end

`ifdef SPI_SLAVE_STATUS_EN
  // Sticky status flags; clear wins over a simultaneous set
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun  <= 1'b0;
      underrun <= 1'b0;
    end else if (status_clr) begin
      overrun  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (ovr_set) overrun  <= 1'b1;
      if (udr_set) underrun <= 1'b1;
    end
  end
`else
  assign overrun  = 1'b0;
  assign underrun = 1'b0;

  logic unused_status;
  assign unused_status = ^{status_clr, ovr_set, udr_set};
`endif

endmodule

// File: tb/tb_spi_slave_base.sv
// tb_spi_slave_base: directed bench for spi_slave_base acting as an SPI mode-0
// master, with hand-computed expected bytes and flag values.
module tb_spi_slave_base;

  localparam int unsigned HALF = 8;

`ifdef SPI_SLAVE_STATUS_EN
  localparam logic EXP_FLAG = 1'b1;
`else
  localparam logic EXP_FLAG = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       ss_n, sck, mosi;
  logic       miso, miso_oe;
  logic [7:0] tx_data;
  logic       tx_load;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, busy, overrun, underrun;
  logic       status_clr;

  int vectors     = 0;
  int miscompares = 0;

  spi_slave_base #(.SYNC_STAGES(2), .IDLE_BYTE(8'h00)) dut (
    .clk        (clk),
    .rst        (rst),
    .ss_n       (ss_n),
    .sck        (sck),
    .mosi       (mosi),
    .miso       (miso),
    .miso_oe    (miso_oe),
    .tx_data    (tx_data),
    .tx_load    (tx_load),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .busy       (busy),
    .overrun    (overrun),
    .underrun   (underrun),
    .status_clr (status_clr)
  );

  always #5 clk = ~clk;

  // rx_valid monitor: counts pulses and high cycles, records the byte per pulse
  int         pulse_cnt = 0;
  int         hi_cnt    = 0;
  logic       rxv_prev  = 1'b0;
  logic [7:0] rxq[$];

  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      hi_cnt++;
      if (rxv_prev !== 1'b1) begin
        pulse_cnt++;
        rxq.push_back(rx_data);
      end
    end
    rxv_prev = rx_valid;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_tx(input logic [7:0] b);
    tx_data = b;
    tx_load = 1'b1;
    tick(1);
    tx_load = 1'b0;
  endtask

  task automatic clr_status();
    status_clr = 1'b1;
    tick(1);
    status_clr = 1'b0;
    tick(1);
  endtask

  task automatic frame_begin();
    ss_n = 1'b0;
    tick(10);
  endtask

  // Clocks n bits MSB first; leaves sck high after the last rising edge
  task automatic shift_bits(input logic [7:0] mo, input int n, output logic [7:0] mi);
    mi = 8'h00;
    for (int k = 0; k < n; k++) begin
      sck  = 1'b0;
      mosi = mo[7-k];
      tick(HALF);
      sck       = 1'b1;
      mi[7-k]   = miso;
      tick(HALF);
    end
  endtask

  task automatic frame_end();
    sck = 1'b0;
    tick(HALF);
    ss_n = 1'b1;
    tick(10);
  endtask

  task automatic check_rx(input string tag, input logic [7:0] exp_v);
    if (rxq.size() > 0) check(tag, rxq.pop_front(), exp_v);
    else check({tag, "_missing"}, 8'hxx, exp_v);
  endtask

  initial begin
    logic [7:0] mi0, mi1;
    int p0, h0;

    rst = 1'b1; ss_n = 1'b1; sck = 1'b0; mosi = 1'b0;
    tx_data = 8'h00; tx_load = 1'b0; status_clr = 1'b0;
    tick(4);
    rst = 1'b0;
    tick(2);

    // Reset values
    check("rst_miso",     8'(miso),     8'h00);
    check("rst_miso_oe",  8'(miso_oe),  8'h00);
    check("rst_tx_ready", 8'(tx_ready), 8'h01);
    check("rst_rx_data",  rx_data,      8'h00);
    check("rst_rx_valid", 8'(rx_valid), 8'h00);
    check("rst_busy",     8'(busy),     8'h00);
    check("rst_overrun",  8'(overrun),  8'h00);
    check("rst_underrun", 8'(underrun), 8'h00);

    // sck/mosi activity with ss_n high is ignored
    for (int i = 0; i < 4; i++) begin
      mosi = i[0];
      sck  = ~sck;
      tick(HALF);
      check("idle_miso_oe", 8'(miso_oe), 8'h00);
    end
    sck = 1'b0;
    tick(HALF);
    check("idle_no_rx", 8'(pulse_cnt), 8'd0);

    // Single byte: slave sends A5, receives 3C
    load_tx(8'hA5);
    check("t2_tx_ready_full", 8'(tx_ready), 8'h00);
    p0 = pulse_cnt; h0 = hi_cnt;
    frame_begin();
    check("t2_miso_oe", 8'(miso_oe), 8'h01);
    check("t2_busy", 8'(busy), 8'h01);
    check("t2_tx_ready_empty", 8'(tx_ready), 8'h01);
    shift_bits(8'h3C, 8, mi0);
    check("t2_underrun", 8'(underrun), 8'h00);
    frame_end();
    check("t2_miso_byte", mi0, 8'hA5);
    check("t2_rx_data", rx_data, 8'h3C);
    check("t2_pulses", 8'(pulse_cnt - p0), 8'd1);
    check("t2_pulse_width", 8'(hi_cnt - h0), 8'd1);
    check_rx("t2_rx_byte", 8'h3C);
    check("t2_miso_oe_off", 8'(miso_oe), 8'h00);

    // Two-byte frame: 12 preloaded, 34 loaded once the first is consumed
    clr_status();
    load_tx(8'h12);
    p0 = pulse_cnt;
    frame_begin();
    check("t3_tx_ready", 8'(tx_ready), 8'h01);
    load_tx(8'h34);
    shift_bits(8'hF0, 8, mi0);
    shift_bits(8'h0F, 8, mi1);
    check("t3_underrun", 8'(underrun), 8'h00);
    frame_end();
    check("t3_miso_b0", mi0, 8'h12);
    check("t3_miso_b1", mi1, 8'h34);
    check("t3_pulses", 8'(pulse_cnt - p0), 8'd2);
    check_rx("t3_rx_b0", 8'hF0);
    check_rx("t3_rx_b1", 8'h0F);

    // Empty buffer at frame start: idle byte goes out, underrun flagged
    clr_status();
    check("t4_underrun_pre", 8'(underrun), 8'h00);
    frame_begin();
    check("t4_underrun_set", 8'(underrun), 8'(EXP_FLAG));
    shift_bits(8'h55, 8, mi0);
    frame_end();
    check("t4_miso_byte", mi0, 8'h00);
    check("t4_rx_data", rx_data, 8'h55);
    check_rx("t4_rx_byte", 8'h55);
    clr_status();
    check("t4_underrun_clr", 8'(underrun), 8'h00);

    // Frame aborted after 5 bits, then a full frame
    p0 = pulse_cnt;
    frame_begin();
    shift_bits(8'hFF, 5, mi0);
    frame_end();
    check("t5_no_pulse", 8'(pulse_cnt - p0), 8'd0);
    check("t5_rx_hold", rx_data, 8'h55);
    check("t5_miso_oe", 8'(miso_oe), 8'h00);
    check("t5_busy", 8'(busy), 8'h00);
    load_tx(8'hC3);
    frame_begin();
    shift_bits(8'h96, 8, mi0);
    frame_end();
    check("t5_miso_byte", mi0, 8'hC3);
    check("t5_rx_data", rx_data, 8'h96);
    check_rx("t5_rx_byte", 8'h96);

    // Double load without a frame: overrun, first byte retained
    clr_status();
    load_tx(8'h11);
    load_tx(8'h22);
    tick(1);
    check("t6_overrun", 8'(overrun), 8'(EXP_FLAG));
    check("t6_tx_ready", 8'(tx_ready), 8'h00);
    frame_begin();
    shift_bits(8'h81, 8, mi0);
    frame_end();
    check("t6_miso_byte", mi0, 8'h11);
    check("t6_rx_data", rx_data, 8'h81);
    check_rx("t6_rx_byte", 8'h81);
    clr_status();
    check("t6_overrun_clr", 8'(overrun), 8'h00);
    check("t6_underrun_clr", 8'(underrun), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
